// File: rtl/vna_sweep_sequencer.sv
// VNA sweep sequencer: decodes UART command bytes into a path list and
// steps the RF switch through it, triggering the VNA and waiting for
// its acquisition-ready edge at every step.
//
// Handshakes: a command is a rising edge of the synchronised rx_new;
// rx_data is sampled in that strobe cycle (the UART holds it stable).
// Each step drives vna_trig high for TRIG_CYCLES. Completion is a rising
// edge of the synchronised acq_rdy, seen either during TRIG or WAIT_ACQ.
// A level that was already high before TRIG does not count.
module vna_sweep_sequencer #(
  parameter int SETTLE_CYCLES      = 50000,
  parameter int TRIG_CYCLES        = 50,
  parameter int ACQ_TIMEOUT_CYCLES = 50000000,
  parameter int LIST_DEPTH         = 8
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_new,
  input  logic       acq_rdy,
  output logic [2:0] sw_sel,
  output logic       vna_trig,
  output logic       busy,
  output logic       err,
  output logic [7:0] status,
  output logic [2:0] dbg_state
);

  localparam int IW = $clog2(LIST_DEPTH);
  localparam int CW = IW + 1;
  localparam logic [25:0]   SETTLE_LAST  = 26'(SETTLE_CYCLES - 1);
  localparam logic [25:0]   TRIG_LAST    = 26'(TRIG_CYCLES - 1);
  localparam logic [25:0]   TIMEOUT_LAST = 26'(ACQ_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LIST_FULL    = CW'(LIST_DEPTH);

  localparam logic [2:0] OP_SET_PATH = 3'b001;
  localparam logic [2:0] OP_LOAD     = 3'b010;
  localparam logic [2:0] OP_CLEAR    = 3'b011;
  localparam logic [2:0] OP_RUN      = 3'b100;
  localparam logic [2:0] OP_STOP     = 3'b101;
  localparam logic [2:0] OP_CLR_ERR  = 3'b110;
  localparam logic [2:0] OP_ILLEGAL  = 3'b111;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    TRIG     = 3'd2,
    WAIT_ACQ = 3'd3,
    NEXT     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      rx_sync_q, acq_sync_q;
  logic [25:0]     cnt_q, cnt_d;
  logic [2:0]      sw_sel_q, sw_sel_d;
  logic            trig_q, trig_d;
  logic            err_q, err_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   idx_q, idx_d, idx_inc;
  logic [3:0]      rep_q, rep_d;
  logic            stop_q, stop_d;
  logic            seen_q, seen_d;
  logic [2:0]      list_q [LIST_DEPTH];
  logic            list_we;
  logic            cmd_stb, acq_evt, is_busy, last_step;
  logic [2:0]      op;
  logic            unused_arg_bit;

  assign op             = rx_data[7:5];
  assign unused_arg_bit = rx_data[4];
  assign cmd_stb        = rx_sync_q[1] & ~rx_sync_q[2];
  assign acq_evt        = acq_sync_q[1] & ~acq_sync_q[2];
  assign is_busy        = (state_q != IDLE);
  assign idx_inc        = idx_q + 1'b1;
  assign last_step      = ({1'b0, idx_q} == (count_q - 1'b1));

  assign sw_sel    = sw_sel_q;
  assign vna_trig  = trig_q;
  assign busy      = is_busy;
  assign err       = err_q;
  assign status    = {is_busy, err_q, 3'(count_q), sw_sel_q};
  assign dbg_state = state_q;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q  <= '0;
      acq_sync_q <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[1:0], rx_new};
      acq_sync_q <= {acq_sync_q[1:0], acq_rdy};
    end
  end

  // Control state registers; reset drops vna_trig asynchronously.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sw_sel_q <= '0;
      trig_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
      idx_q    <= '0;
      rep_q    <= '0;
      stop_q   <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sw_sel_q <= sw_sel_d;
      trig_q   <= trig_d;
      err_q    <= err_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      rep_q    <= rep_d;
      stop_q   <= stop_d;
      seen_q   <= seen_d;
    end
  end

  // Path list storage, appended by LOAD.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LIST_DEPTH; i++) list_q[i] <= '0;
    end else if (list_we) begin
      list_q[count_q[IW-1:0]] <= rx_data[2:0];
    end
  end

  // Command decode followed by sweep sequencing; the shared counter
  // restarts on every state change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (state_q == IDLE) ? '0 : cnt_q + 26'd1;
    sw_sel_d = sw_sel_q;
    trig_d   = trig_q;
    err_d    = err_q;
    count_d  = count_q;
    idx_d    = idx_q;
    rep_d    = rep_q;
    stop_d   = stop_q;
    seen_d   = seen_q;
    list_we  = 1'b0;

    if (cmd_stb) begin
      case (op)
        OP_SET_PATH: begin
          if (is_busy) err_d = 1'b1;
          else         sw_sel_d = rx_data[2:0];
        end
        OP_LOAD: begin
          if (is_busy || count_q == LIST_FULL) begin
            err_d = 1'b1;
          end else begin
            list_we = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
        OP_CLEAR: begin
          if (is_busy) err_d = 1'b1;
          else         count_d = '0;
        end
        OP_RUN: begin
          if (is_busy || count_q == '0) begin
            err_d = 1'b1;
          end else begin
            rep_d    = rx_data[3:0];
            idx_d    = '0;
            stop_d   = 1'b0;
            state_d  = SETTLE;
            sw_sel_d = list_q[0];
          end
        end
        OP_STOP:    if (is_busy) stop_d = 1'b1;
        OP_CLR_ERR: err_d = 1'b0;
        OP_ILLEGAL: err_d = 1'b1;
        default: ;
      endcase
    end

    case (state_q)
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = TRIG;
          trig_d  = 1'b1;
          seen_d  = 1'b0;
        end
      end
      TRIG: begin
        if (acq_evt) seen_d = 1'b1;
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_ACQ;
          trig_d  = 1'b0;
        end
      end
      WAIT_ACQ: begin
        if (seen_q || acq_evt) begin
          state_d = NEXT;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          stop_d  = 1'b0;
          state_d = IDLE;
        end
      end
      NEXT: begin
        if (stop_q) begin
          stop_d  = 1'b0;
          state_d = IDLE;
        end else if (last_step) begin
          idx_d = '0;
          if (rep_q == 4'd1) begin
            state_d = IDLE;
          end else begin
            if (rep_q > 4'd1) rep_d = rep_q - 4'd1;
            state_d  = SETTLE;
            sw_sel_d = list_q[0];
          end
        end else begin
          idx_d    = idx_inc;
          state_d  = SETTLE;
          sw_sel_d = list_q[idx_inc];
        end
      end
      default: ;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

endmodule

// File: tb/tb_vna_sweep_sequencer.sv
// Bench for vna_sweep_sequencer with shortened timing parameters.
module tb_vna_sweep_sequencer;

  localparam int SETTLE = 4;
  localparam int TRIGW  = 2;
  localparam int TMO    = 20;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd3;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] exp_status;
  } vec_t;

  logic       clk_50 = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_new;
  logic       acq_rdy;
  logic [2:0] sw_sel;
  logic       vna_trig, busy, err;
  logic [7:0] status;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];
  int  ntrig = 0;
  bit  mon_en = 0;
  int  resp_mode = 0;
  logic acq_lvl = 1'b0;

  vna_sweep_sequencer #(
    .SETTLE_CYCLES(SETTLE), .TRIG_CYCLES(TRIGW),
    .ACQ_TIMEOUT_CYCLES(TMO), .LIST_DEPTH(8)
  ) dut (
    .clk_50(clk_50), .rst_n(rst_n), .rx_data(rx_data), .rx_new(rx_new),
    .acq_rdy(acq_rdy), .sw_sel(sw_sel), .vna_trig(vna_trig), .busy(busy),
    .err(err), .status(status), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk_50 = ~clk_50;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b);
    rx_data = b;
    rx_new  = 1'b1;
    tick(3);
    rx_new  = 1'b0;
    tick(3);
  endtask

  task automatic wait_trig(int max, string name);
    for (int i = 0; i < max && vna_trig !== 1'b1; i++) tick(1);
    check(name, vna_trig, 1);
  endtask

  task automatic wait_state(logic [2:0] s, int max, string name);
    for (int i = 0; i < max && dbg_state !== s; i++) tick(1);
    check(name, dbg_state, s);
  endtask

  task automatic wait_idle(int max, string name);
    for (int i = 0; i < max && busy !== 1'b0; i++) tick(1);
    check(name, busy, 0);
  endtask

  // Acquisition responder: level-follow, random delay, or fixed 3-cycle delay.
  initial begin
    logic tp;
    int d;
    tp = 1'b0;
    acq_rdy = 1'b0;
    forever begin
      @(negedge clk_50);
      if (resp_mode == 0) begin
        acq_rdy = acq_lvl;
      end else if (vna_trig && !tp) begin
        d = (resp_mode == 2) ? 3 : int'($urandom_range(1, 6));
        repeat (d) @(negedge clk_50);
        acq_rdy = 1'b1;
        repeat (3) @(negedge clk_50);
        acq_rdy = 1'b0;
      end
      tp = vna_trig;
    end
  end

  // Trigger monitor: path per trigger, settle-to-trigger gap, pulse width.
  initial begin
    int cyc, settle_cyc, rise_cyc;
    logic tprev;
    logic [2:0] sprev;
    cyc = 0; settle_cyc = 0; rise_cyc = 0; tprev = 1'b0; sprev = 3'd0;
    forever begin
      @(negedge clk_50);
      cyc++;
      if (dbg_state == ST_SETTLE && sprev != ST_SETTLE) settle_cyc = cyc;
      if (mon_en) begin
        if (vna_trig && !tprev) begin
          rise_cyc = cyc;
          ntrig++;
          check("trig_gap", cyc - settle_cyc, SETTLE);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_trig: got trigger on path %0d, expected none", sw_sel);
          end else begin
            check("trig_path", sw_sel, exp_q.pop_front());
          end
        end
        if (!vna_trig && tprev) check("trig_width", cyc - rise_cyc, TRIGW);
      end
      tprev = vna_trig;
      sprev = dbg_state;
    end
  end

  // Main sequence.
  initial begin
    vec_t vecs[12];
    logic [2:0] lst[$];
    logic [7:0] busy_cmds[4];
    logic [2:0] v;
    int len, rep;

    vecs[0]  = '{8'h26, 8'h06};
    vecs[1]  = '{8'h00, 8'h06};
    vecs[2]  = '{8'hE5, 8'h46};
    vecs[3]  = '{8'hC0, 8'h06};
    vecs[4]  = '{8'h80, 8'h46};
    vecs[5]  = '{8'hC0, 8'h06};
    vecs[6]  = '{8'hA0, 8'h06};
    vecs[7]  = '{8'h43, 8'h0E};
    vecs[8]  = '{8'h4D, 8'h16};
    vecs[9]  = '{8'h60, 8'h06};
    vecs[10] = '{8'h3F, 8'h07};
    vecs[11] = '{8'h21, 8'h01};
    busy_cmds[0] = 8'h26;
    busy_cmds[1] = 8'h41;
    busy_cmds[2] = 8'h60;
    busy_cmds[3] = 8'h81;

    // reset with rx_new toggling and acq_rdy high
    rst_n = 1'b0; rx_data = 8'h80; rx_new = 1'b0; acq_lvl = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rx_new = ~rx_new;
      tick(1);
      check("reset_status", status, 8'h00);
      check("reset_trig", vna_trig, 0);
    end
    rx_new = 1'b0; acq_lvl = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(4);
    check("post_reset_status", status, 8'h00);
    mon_en = 1;

    // IDLE command table
    for (int i = 0; i < 12; i++) begin
      send_byte(vecs[i].cmd);
      check($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
    end

    // SET_PATH latency from rx_new rising
    rx_data = 8'h26; rx_new = 1'b1;
    tick(4);
    check("setpath_latency", sw_sel, 6);
    rx_new = 1'b0;
    tick(3);

    // nine LOADs: the ninth is rejected
    for (int i = 0; i < 9; i++) begin
      v = 3'($urandom_range(0, 7));
      send_byte(8'h40 | {5'b0, v});
      if (i < 8) lst.push_back(v);
      check("load_status", status, {1'b0, (i == 8), 3'((i < 8) ? i + 1 : 8), 3'd6});
    end
    send_byte(8'hC0);
    foreach (lst[i]) exp_q.push_back(lst[i]);
    resp_mode = 1;
    send_byte(8'h81);
    wait_idle(600, "full_run_idle");
    check("full_run_left", exp_q.size(), 0);
    check("full_run_status", status, {5'b0, lst[7]});
    send_byte(8'h60);
    check("clear_status", status, {5'b0, lst[7]});
    send_byte(8'h80);
    check("run_empty_status", status, {2'b01, 3'b0, lst[7]});
    tick(10);
    check("run_empty_busy", busy, 0);
    send_byte(8'hC0);

    // LOAD 3, LOAD 5, RUN x2 with acq 3 cycles after each trigger
    resp_mode = 2;
    send_byte(8'h43);
    send_byte(8'h45);
    exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(3); exp_q.push_back(5);
    ntrig = 0;
    rx_data = 8'h82; rx_new = 1'b1;
    tick(6);
    check("run_lat_low", vna_trig, 0);
    tick(1);
    check("run_lat_high", vna_trig, 1);
    rx_new = 1'b0;
    wait_idle(300, "seq_idle");
    check("seq_ntrig", ntrig, 4);
    check("seq_left", exp_q.size(), 0);
    check("seq_status", status, 8'h15);

    // acquisition timeout
    resp_mode = 0; acq_lvl = 1'b0;
    send_byte(8'h60);
    send_byte(8'h42);
    exp_q.push_back(2);
    send_byte(8'h81);
    wait_state(ST_WAIT, 50, "wait_entry");
    tick(TMO - 1);
    check("timeout_busy_early", busy, 1);
    check("timeout_err_early", err, 0);
    tick(1);
    check("timeout_busy", busy, 0);
    check("timeout_err", err, 1);
    send_byte(8'hC0);
    check("clr_err", err, 0);

    // acq edge landing during TRIG still completes the step
    exp_q.push_back(2);
    rx_data = 8'h81; rx_new = 1'b1;
    tick(5);
    acq_lvl = 1'b1;
    tick(2);
    check("early_acq_trig", vna_trig, 1);
    rx_new = 1'b0;
    wait_idle(12, "early_acq_idle");
    check("early_acq_err", err, 0);
    acq_lvl = 1'b0;
    tick(5);

    // acq already high before TRIG does not count
    acq_lvl = 1'b1;
    tick(4);
    exp_q.push_back(2);
    send_byte(8'h81);
    wait_idle(60, "prehigh_idle");
    check("prehigh_err", err, 1);
    acq_lvl = 1'b0;
    send_byte(8'hC0);

    // continuous run stopped during TRIG
    resp_mode = 2;
    send_byte(8'h60);
    send_byte(8'h41);
    send_byte(8'h44);
    exp_q.push_back(1); exp_q.push_back(4);
    ntrig = 0;
    send_byte(8'h80);
    wait_trig(30, "cont_first_trig");
    wait_state(ST_SETTLE, 40, "cont_second_settle");
    tick(2);
    rx_data = 8'hA0; rx_new = 1'b1;
    tick(2);
    check("stop_in_trig", vna_trig, 1);
    tick(1);
    rx_new = 1'b0;
    wait_idle(100, "stop_idle");
    tick(50);
    check("stop_ntrig", ntrig, 2);
    check("stop_left", exp_q.size(), 0);
    check("stop_status", status, 8'h14);

    // randomized sweeps against the list/repeat model, with a command
    // that must be refused while busy
    resp_mode = 1;
    for (int s = 0; s < 4; s++) begin
      send_byte(8'h60);
      lst.delete();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        v = 3'($urandom_range(0, 7));
        lst.push_back(v);
        send_byte(8'h40 | {5'b0, v});
      end
      rep = $urandom_range(1, 3);
      for (int r = 0; r < rep; r++)
        foreach (lst[i]) exp_q.push_back(lst[i]);
      ntrig = 0;
      send_byte(8'h80 | 8'(rep));
      wait_trig(20, "rand_first_trig");
      send_byte((s == 0) ? busy_cmds[0] : busy_cmds[$urandom_range(0, 3)]);
      wait_idle(1000, "rand_idle");
      check("rand_ntrig", ntrig, len * rep);
      check("rand_left", exp_q.size(), 0);
      check("rand_status", status, {2'b01, 3'(len), lst[len - 1]});
      send_byte(8'hC0);
    end

    // reset asserted during TRIG
    mon_en = 0;
    resp_mode = 0; acq_lvl = 1'b0;
    send_byte(8'h81);
    wait_trig(20, "rst_trig_seen");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_trig", vna_trig, 0);
    check("rst_async_status", status, 8'h00);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check("rst_after_status", status, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vna_sweep_sequencer.md
Name: vna_sweep_sequencer

Overview:
Command-driven controller for the VNA RF switch and the VNA trigger/acquire handshake, clocked on clk_50.
- Takes decoded bytes from the UART receiver (byte plus new-data flag) and keeps a path list of up to 8 entries.
- On RUN it steps through the list. Per step: drive the 3-bit switch select, wait for settling, pulse the VNA trigger, wait for ACQ-RDY.
- Its outputs drive the switch-select GPIOs, VNA-TRIG and the debug LEDs.

Parameters:
- SETTLE_CYCLES, 50000: clk_50 cycles the switch select is held before the trigger (1 ms).
- TRIG_CYCLES, 50: width of the vna_trig pulse in cycles (1 us).
- ACQ_TIMEOUT_CYCLES, 50000000: maximum cycles to wait for an acq_rdy rising edge (1 s).
- LIST_DEPTH, 8: number of path-list entries (power of 2).

Ports:
- clk_50, input, 1: system clock, 50 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- rx_data, input, 8: UART byte. Held stable while rx_new is high.
- rx_new, input, 1: UART new-data flag. Comes from the UART clock domain, so it is asynchronous to clk_50.
- acq_rdy, input, 1: VNA acquisition-ready. Asynchronous.
- sw_sel, output, 3: RF switch path select.
- vna_trig, output, 1: VNA trigger pulse, active-high.
- busy, output, 1: high while a sweep is running.
- err, output, 1: sticky error flag.
- status, output, 8: {busy, err, list_count[2:0], sw_sel[2:0]} for the LEDs.

Behaviour:
Reset values:
- sw_sel=0, vna_trig=0, busy=0, err=0.
- List empty, repeat counter=0, state IDLE.
- Reset mid-sweep aborts immediately: vna_trig drops asynchronously and no state is retained.

Input synchronisation:
- rx_new and acq_rdy each pass through a 2-flop synchroniser.
- Command strobe = rising edge of synced rx_new. rx_data is captured on that cycle.
- acq event = rising edge of synced acq_rdy.

Command byte layout: op=rx_data[7:5], arg=rx_data[4:0].
- 000 NOP: no effect.
- 001 SET_PATH: in IDLE, sw_sel<=arg[2:0] on the cycle after the strobe. While busy: ignored, err<=1.
- 010 LOAD: in IDLE with list not full, list[count]<=arg[2:0] and count++. If full (count==LIST_DEPTH) or busy: ignored, err<=1.
- 011 CLEAR: in IDLE, count<=0. While busy: ignored, err<=1.
- 100 RUN: in IDLE with count>0, load repeat<=arg[3:0], idx<=0, go to SETTLE, busy<=1.
  - repeat 0 means run continuously until STOP.
  - count==0 or already busy: err<=1, no state change.
- 101 STOP: while busy, sets stop_req. While IDLE: no effect.
- 110 CLR_ERR: err<=0.
- 111: illegal, err<=1.
- Only one strobe is processed per cycle. Strobes are at least ~1 ms apart at 9600 baud.

State machine (IDLE, SETTLE, TRIG, WAIT_ACQ, NEXT):
- SETTLE:
  - On entry sw_sel<=list[idx] and the counter is cleared.
  - After SETTLE_CYCLES cycles go to TRIG.
- TRIG:
  - vna_trig=1 for exactly TRIG_CYCLES cycles, then WAIT_ACQ.
  - An acq event seen during TRIG is recorded and satisfies WAIT_ACQ. An acq_rdy level that was already high before TRIG began does not count.
- WAIT_ACQ:
  - On an acq event go to NEXT.
  - If the counter reaches ACQ_TIMEOUT_CYCLES: err<=1, go to IDLE, busy<=0.
- NEXT (1 cycle):
  - If stop_req: go to IDLE and clear stop_req.
  - Else if idx==count-1: idx<=0.
    - If repeat==1, go to IDLE.
    - Else if repeat>1, repeat-- and go to SETTLE.
    - Else (repeat 0, continuous) go to SETTLE.
  - Else idx++ and go to SETTLE.
- On return to IDLE: busy<=0, sw_sel holds the last path, and the list is preserved.
- STOP never truncates a trigger or acquisition in progress.

Widths and sequencing:
- The 26-bit counter is shared across states and cleared on every state change.
- vna_trig is registered and glitch-free.
- Step latency from RUN strobe to vna_trig rising = 1 + SETTLE_CYCLES cycles.

Test Plan:
Tests 2, 3 and 5 use SETTLE=4, TRIG=2, TIMEOUT=20.
1. Reset with rx_new toggling and acq_rdy high -> all outputs 0, status=0x00, no vna_trig for 100 cycles.
2. LOAD 3, LOAD 5, RUN arg=2 (bytes 0x43, 0x45, 0x82); respond to each trig with acq_rdy rising 3 cycles later -> sw_sel sequence 3,5,3,5, four 2-cycle vna_trig pulses, each 4 cycles after its sw_sel change, then busy=0 and sw_sel=5.
3. Single-entry list, RUN, acq_rdy never rises -> err=1 and busy=0 at 20 cycles after WAIT_ACQ entry; CLR_ERR (0xC0) -> err=0.
4. LOAD 9 times -> count=8, err=1, ninth entry absent. RUN with empty list after CLEAR (0x60, 0x80) -> err=1, busy stays 0.
5. RUN arg=0 (continuous) with 2 entries, STOP (0xA0) sent during TRIG -> the pulse completes full width, acquisition completes, then IDLE, with no further trigger.
6. SET_PATH 6 (0x26) in IDLE -> sw_sel=6 within 4 cycles of the rx_new rising edge. The same command while busy -> sw_sel unchanged, err=1. Reset asserted during TRIG -> vna_trig=0 immediately.
